// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with static select or round-robin arbitration.
// One-cycle latency; lock holds a round-robin grant while its request stays high.
module mux_arb_n #(
  parameter int unsigned SIGNAL_WIDTH = 8,
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned SEL_WIDTH    = 3,
  parameter int unsigned ARB_MODE     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*SIGNAL_WIDTH-1:0] in_flat,
  input  logic [NUM_CH-1:0]              req,
  input  logic [SEL_WIDTH-1:0]           selector,
  input  logic                           en,
  input  logic                           lock,
  output logic [SIGNAL_WIDTH-1:0]        out,
  output logic                           out_valid,
  output logic [NUM_CH-1:0]              grant,
  output logic [SEL_WIDTH-1:0]           grant_idx
);

  typedef enum logic [2:0] {
    D_HOLD,
    D_SELECT,
    D_BAD_SEL,
    D_LOCKED,
    D_ARBITRATE,
    D_IDLE
  } decision_e;

  decision_e                decision;
  logic [SIGNAL_WIDTH-1:0]  ch [NUM_CH];
  logic [SEL_WIDTH-1:0]     ptr;
  logic [SEL_WIDTH-1:0]     ptr_nxt;
  logic [SEL_WIDTH-1:0]     pick;
  logic [SEL_WIDTH-1:0]     cand;
  logic [SEL_WIDTH-1:0]     rr_win;
  logic                     rr_found;
  logic [SIGNAL_WIDTH-1:0]  out_nxt;
  logic                     valid_nxt;
  logic [NUM_CH-1:0]        grant_nxt;
  logic [SEL_WIDTH-1:0]     idx_nxt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch[k] = in_flat[k*SIGNAL_WIDTH +: SIGNAL_WIDTH];
  end

  // Rotating-priority search: starts just after the last winner, ends on it.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = SEL_WIDTH'((32'(ptr) + i) % NUM_CH);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  // Per-cycle decision and the next register values it implies.
  always_comb begin
    decision  = D_HOLD;
    pick      = grant_idx;
    out_nxt   = out;
    valid_nxt = 1'b0;
    grant_nxt = '0;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;

    if (!en) begin
      decision = D_HOLD;
    end else if (ARB_MODE == 0) begin
      pick     = selector;
      decision = (32'(selector) < NUM_CH) ? D_SELECT : D_BAD_SEL;
    end else if (lock && (grant != '0) && req[grant_idx]) begin
      decision = D_LOCKED;
      pick     = grant_idx;
    end else if (rr_found) begin
      decision = D_ARBITRATE;
      pick     = rr_win;
    end else begin
      decision = D_IDLE;
    end

    case (decision)
      D_SELECT: begin
        out_nxt   = ch[pick];
        valid_nxt = 1'b1;
        grant_nxt = NUM_CH'(1) << pick;
        idx_nxt   = pick;
      end
      D_BAD_SEL: begin
        out_nxt = '0;
      end
      D_LOCKED: begin
        out_nxt   = ch[pick];
        valid_nxt = 1'b1;
        grant_nxt = grant;
      end
      D_ARBITRATE: begin
        out_nxt   = ch[pick];
        valid_nxt = 1'b1;
        grant_nxt = NUM_CH'(1) << pick;
        idx_nxt   = pick;
        ptr_nxt   = pick;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= SEL_WIDTH'(NUM_CH - 1);
    end else begin
      out       <= out_nxt;
      out_valid <= valid_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: one SELECT-mode and one ROUND_ROBIN-mode instance
// share stimulus; each task checks the instance its scenario targets.
module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_flat;
  logic [7:0]  req;
  logic [2:0]  selector;
  logic        en;
  logic        lock;

  logic [7:0]  s_out, r_out;
  logic        s_valid, r_valid;
  logic [7:0]  s_grant, r_grant;
  logic [2:0]  s_idx, r_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.SIGNAL_WIDTH(8), .NUM_CH(8), .SEL_WIDTH(3), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_flat(in_flat), .req(req), .selector(selector),
    .en(en), .lock(lock), .out(s_out), .out_valid(s_valid), .grant(s_grant),
    .grant_idx(s_idx)
  );

  mux_arb_n #(.SIGNAL_WIDTH(8), .NUM_CH(8), .SEL_WIDTH(3), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_flat(in_flat), .req(req), .selector(selector),
    .en(en), .lock(lock), .out(r_out), .out_valid(r_valid), .grant(r_grant),
    .grant_idx(r_idx)
  );

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 8; k++) in_flat[k*8 +: 8] = 8'(8'h10 + k);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; lock = 1'b0; req = 8'h00; selector = 3'd0;
    load_ramp();
    step();
    step();
    n_vec++;
    if (s_out !== 8'h00 || s_valid !== 1'b0 || s_grant !== 8'h00 || s_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_sel got out=%h v=%b g=%b i=%0d want 00/0/0/0", s_out, s_valid, s_grant, s_idx);
    end
    n_vec++;
    if (r_out !== 8'h00 || r_valid !== 1'b0 || r_grant !== 8'h00 || r_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_rr got out=%h v=%b g=%b i=%0d want 00/0/0/0", r_out, r_valid, r_grant, r_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_select_basic();
    logic [7:0] exp_d;
    logic [2:0] sel;
    load_ramp();
    selector = 3'd5; en = 1'b1;
    step();
    n_vec++;
    if (s_out !== 8'h15 || s_valid !== 1'b1 || s_grant !== 8'b0010_0000 || s_idx !== 3'd5) begin
      n_err++;
      $display("FAIL sel5 got out=%h v=%b g=%b i=%0d want 15/1/00100000/5", s_out, s_valid, s_grant, s_idx);
    end
    for (int n = 0; n < 30; n++) begin
      in_flat  = {$urandom(), $urandom()};
      sel      = 3'($urandom_range(0, 7));
      selector = sel;
      exp_d    = in_flat[sel*8 +: 8];
      step();
      n_vec++;
      if (s_out !== exp_d || s_grant !== (8'd1 << sel) || s_idx !== sel || s_valid !== 1'b1) begin
        n_err++;
        $display("FAIL sel_rand[%0d] sel=%0d got out=%h g=%b i=%0d v=%b want out=%h g=%b", n, sel,
                 s_out, s_grant, s_idx, s_valid, exp_d, 8'd1 << sel);
      end
    end
  endtask

  task automatic test_select_hold();
    load_ramp();
    selector = 3'd5; en = 1'b1;
    step();
    en = 1'b0; selector = 3'd2;
    for (int n = 0; n < 3; n++) begin
      step();
      n_vec++;
      if (s_out !== 8'h15 || s_valid !== 1'b0 || s_grant !== 8'h00 || s_idx !== 3'd5) begin
        n_err++;
        $display("FAIL sel_hold[%0d] got out=%h v=%b g=%b i=%0d want 15/0/0/5", n, s_out, s_valid, s_grant, s_idx);
      end
    end
    en = 1'b1;
    step();
    n_vec++;
    if (s_out !== 8'h12 || s_valid !== 1'b1 || s_idx !== 3'd2) begin
      n_err++;
      $display("FAIL sel_resume got out=%h v=%b i=%0d want 12/1/2", s_out, s_valid, s_idx);
    end
  endtask

  task automatic test_rr_fairness();
    logic [2:0] e;
    rst = 1'b1; step(); rst = 1'b0;
    load_ramp();
    req = 8'hFF; en = 1'b1; lock = 1'b0;
    for (int n = 0; n < 9; n++) begin
      e = 3'(n % 8);
      step();
      n_vec++;
      if (r_idx !== e || r_valid !== 1'b1 || r_out !== 8'(8'h10 + e) || r_grant !== (8'd1 << e)) begin
        n_err++;
        $display("FAIL rr_fair[%0d] got i=%0d v=%b out=%h g=%b want i=%0d", n, r_idx, r_valid, r_out, r_grant, e);
      end
    end
  endtask

  task automatic test_rr_sparse_wrap();
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd1; exp_seq[1] = 3'd7; exp_seq[2] = 3'd1; exp_seq[3] = 3'd7;
    req = 8'b1000_0010;
    for (int n = 0; n < 4; n++) begin
      step();
      n_vec++;
      if (r_idx !== exp_seq[n] || r_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rr_sparse[%0d] got i=%0d v=%b want i=%0d v=1", n, r_idx, r_valid, exp_seq[n]);
      end
    end
    req = 8'h00;
    step();
    n_vec++;
    if (r_grant !== 8'h00 || r_valid !== 1'b0 || r_out !== 8'h17 || r_idx !== 3'd7) begin
      n_err++;
      $display("FAIL rr_idle got g=%b v=%b out=%h i=%0d want 0/0/17/7", r_grant, r_valid, r_out, r_idx);
    end
    req = 8'hFF;
    step();
    n_vec++;
    if (r_idx !== 3'd0 || r_grant !== 8'h01 || r_out !== 8'h10) begin
      n_err++;
      $display("FAIL rr_after_idle got i=%0d g=%b out=%h want 0/00000001/10", r_idx, r_grant, r_out);
    end
  endtask

  task automatic test_rr_lock();
    req = 8'hFF; lock = 1'b0;
    step();
    step();
    n_vec++;
    if (r_idx !== 3'd2) begin
      n_err++;
      $display("FAIL rr_lock_pre got i=%0d want 2", r_idx);
    end
    lock = 1'b1;
    for (int n = 0; n < 4; n++) begin
      in_flat[2*8 +: 8] = 8'(8'hA0 + n);
      step();
      n_vec++;
      if (r_idx !== 3'd2 || r_grant !== 8'h04 || r_valid !== 1'b1 || r_out !== 8'(8'hA0 + n)) begin
        n_err++;
        $display("FAIL rr_lock[%0d] got i=%0d g=%b v=%b out=%h want 2/00000100/1/%h", n, r_idx, r_grant,
                 r_valid, r_out, 8'(8'hA0 + n));
      end
    end
    req = 8'hFB;
    step();
    n_vec++;
    if (r_idx !== 3'd3 || r_out !== 8'h13) begin
      n_err++;
      $display("FAIL rr_lock_release got i=%0d out=%h want 3/13", r_idx, r_out);
    end
    load_ramp();
  endtask

  task automatic test_rr_reset_mid();
    req = 8'hFF; lock = 1'b0;
    step();
    step();
    n_vec++;
    if (r_idx !== 3'd5) begin
      n_err++;
      $display("FAIL rr_mid_pre got i=%0d want 5", r_idx);
    end
    lock = 1'b1; rst = 1'b1;
    step();
    n_vec++;
    if (r_out !== 8'h00 || r_valid !== 1'b0 || r_grant !== 8'h00) begin
      n_err++;
      $display("FAIL rr_mid_rst got out=%h v=%b g=%b want 00/0/0", r_out, r_valid, r_grant);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (r_idx !== 3'd0 || r_grant !== 8'h01 || r_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rr_mid_first got i=%0d g=%b v=%b want 0/00000001/1", r_idx, r_grant, r_valid);
    end
  endtask

  task automatic test_rr_en_hold();
    lock = 1'b0; req = 8'hFF; en = 1'b0;
    step();
    n_vec++;
    if (r_idx !== 3'd0 || r_grant !== 8'h00 || r_valid !== 1'b0 || r_out !== 8'h10) begin
      n_err++;
      $display("FAIL rr_en0 got i=%0d g=%b v=%b out=%h want 0/0/0/10", r_idx, r_grant, r_valid, r_out);
    end
    en = 1'b1;
    step();
    n_vec++;
    if (r_idx !== 3'd1) begin
      n_err++;
      $display("FAIL rr_en_resume got i=%0d want 1", r_idx);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; lock = 1'b0; req = '0; selector = '0; in_flat = '0;
    test_reset();
    test_select_basic();
    test_select_hold();
    test_rr_fairness();
    test_rr_sparse_wrap();
    test_rr_lock();
    test_rr_reset_mid();
    test_rr_en_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
